// File: rtl/emergency_preempt_arbiter.sv
// Emergency-vehicle preemption controller for the traffic-light controller.
// Per-lane emergency requests are latched per direction and served round-robin.
// Each grant gets an all-red clearance, then a green hold with bounded extensions.
// While the hold is active the block overrides normal phasing through laneOutput.
module emergency_preempt_arbiter #(
   parameter int NUM_DIRS      = 4,
   parameter int LANES_PER_DIR = 2,
   parameter int TIME_W        = 7,
   parameter int HOLD_TIME     = 4,
   parameter int CLEAR_TIME    = 2,
   parameter int MAX_EXT       = 2,
   parameter int DIR_W         = (NUM_DIRS > 1) ? $clog2(NUM_DIRS) : 1
) (
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic                                  tick,
   input  logic [0:NUM_DIRS*LANES_PER_DIR-1]     emergencyLane,
   output logic [0:NUM_DIRS*LANES_PER_DIR-1]     laneOutput,
   output logic                                  loadCommand,
   output logic [TIME_W-1:0]                     loadTime,
   output logic                                  active,
   output logic [DIR_W-1:0]                      activeDir
);

   localparam int NL = NUM_DIRS * LANES_PER_DIR;

   localparam logic [TIME_W-1:0] HOLD_VAL  = TIME_W'(HOLD_TIME);
   localparam logic [TIME_W-1:0] CLEAR_VAL = TIME_W'(CLEAR_TIME);
   localparam logic [TIME_W-1:0] EXT_MAX   = TIME_W'(MAX_EXT);
   localparam logic [TIME_W-1:0] ONE       = TIME_W'(1);

   // Timer values must fit in the TIME_W-bit counter, and a grant needs a nonzero hold
   generate
      if (HOLD_TIME < 1 || HOLD_TIME >= (1 << TIME_W) ||
          CLEAR_TIME < 0 || CLEAR_TIME >= (1 << TIME_W) ||
          MAX_EXT < 0 || MAX_EXT >= (1 << TIME_W)) begin : g_bad_params
         $error("emergency_preempt_arbiter: HOLD_TIME, CLEAR_TIME or MAX_EXT out of range for TIME_W");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE,
      CLEAR,
      GRANT
   } state_t;

   state_t              state;
   logic [NUM_DIRS-1:0] pending;
   logic [NUM_DIRS-1:0] next_pending;
   logic [NUM_DIRS-1:0] dir_req;
   logic [DIR_W-1:0]    rr_ptr;
   logic [DIR_W-1:0]    rr_next;
   logic [DIR_W-1:0]    winner;
   logic [DIR_W:0]      search_idx;
   logic                found;
   logic                any_pending;
   logic [TIME_W-1:0]   cnt;
   logic [TIME_W-1:0]   ext;
   logic                hold_expiring;
   logic                extend;
   logic                grant_done;

   // Lane mask covering every lane of one direction
   function automatic logic [0:NL-1] dir_mask(input logic [DIR_W-1:0] dir);
      logic [0:NL-1] m;
      m = '0;
      for (int i = 0; i < NL; i++) begin
         if ((i / LANES_PER_DIR) == int'(dir)) begin
            m[i] = 1'b1;
         end
      end
      return m;
   endfunction

   // A direction requests when any of its lanes does
   always_comb begin
      dir_req = '0;
      for (int d = 0; d < NUM_DIRS; d++) begin
         for (int l = 0; l < LANES_PER_DIR; l++) begin
            dir_req[d] = dir_req[d] | emergencyLane[d*LANES_PER_DIR + l];
         end
      end
   end

   // Round-robin search over pending, starting at rr_ptr and wrapping
   always_comb begin
      winner     = '0;
      found      = 1'b0;
      search_idx = '0;
      for (int k = 0; k < NUM_DIRS; k++) begin
         search_idx = {1'b0, rr_ptr} + (DIR_W+1)'(k);
         if (search_idx >= (DIR_W+1)'(NUM_DIRS)) begin
            search_idx = search_idx - (DIR_W+1)'(NUM_DIRS);
         end
         if (!found && pending[search_idx[DIR_W-1:0]]) begin
            found  = 1'b1;
            winner = search_idx[DIR_W-1:0];
         end
      end
   end

   assign any_pending   = |pending;
   assign hold_expiring = (state == GRANT) && tick && (cnt == ONE);
   assign extend        = hold_expiring && dir_req[activeDir] && (ext < EXT_MAX);
   assign grant_done    = hold_expiring && !extend;
   assign rr_next       = (activeDir == DIR_W'(NUM_DIRS-1)) ? '0 : activeDir + DIR_W'(1);

   // Pending requests stick until served; a still-asserted request survives its own grant end
   always_comb begin
      next_pending = pending;
      if (grant_done) begin
         next_pending[activeDir] = 1'b0;
      end
      next_pending = next_pending | dir_req;
   end

   // Main controller: request latching, arbitration, clearance and hold timing, registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         laneOutput  <= '0;
         loadCommand <= 1'b0;
         loadTime    <= '0;
         active      <= 1'b0;
         activeDir   <= '0;
         pending     <= '0;
         rr_ptr      <= '0;
         cnt         <= '0;
         ext         <= '0;
      end else begin
         pending     <= next_pending;
         loadCommand <= 1'b0;
         loadTime    <= '0;
         case (state)
            IDLE: begin
               laneOutput <= '0;
               active     <= 1'b0;
               if (any_pending) begin
                  activeDir <= winner;
                  active    <= 1'b1;
                  if (CLEAR_TIME == 0) begin
                     state       <= GRANT;
                     cnt         <= HOLD_VAL;
                     ext         <= '0;
                     loadCommand <= 1'b1;
                     loadTime    <= HOLD_VAL;
                     laneOutput  <= dir_mask(winner);
                  end else begin
                     state <= CLEAR;
                     cnt   <= CLEAR_VAL;
                  end
               end
            end
            CLEAR: begin
               if (tick) begin
                  if (cnt == ONE) begin
                     state       <= GRANT;
                     cnt         <= HOLD_VAL;
                     ext         <= '0;
                     loadCommand <= 1'b1;
                     loadTime    <= HOLD_VAL;
                     laneOutput  <= dir_mask(activeDir);
                  end else begin
                     cnt <= cnt - ONE;
                  end
               end
            end
            GRANT: begin
               if (tick) begin
                  if (extend) begin
                     cnt         <= HOLD_VAL;
                     ext         <= ext + ONE;
                     loadCommand <= 1'b1;
                     loadTime    <= HOLD_VAL;
                  end else if (grant_done) begin
                     state      <= IDLE;
                     laneOutput <= '0;
                     active     <= 1'b0;
                     activeDir  <= '0;
                     rr_ptr     <= rr_next;
                     cnt        <= '0;
                     ext        <= '0;
                  end else begin
                     cnt <= cnt - ONE;
                  end
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
